// File: rtl/nway_wb_cache_ctrl_if.sv
// Purpose : CPU request/response and block-wide memory req/ack bundle for nway_wb_cache_ctrl.
// Modports: master - CPU/memory side (drives requests, memory acks and refill data)
//           slave  - cache controller (accepts CPU requests, issues memory requests)
// Signals : cpu_req_valid/ready/type, cpu_addr, cpu_wdata, cpu_resp_valid, cpu_rdata,
//           mem_req_valid/we, mem_addr, mem_wdata, mem_ack, mem_rdata
interface nway_wb_cache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned BLOCK_SIZE = 128
);
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_type;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [WORD_SIZE-1:0]  cpu_wdata;
  logic                  cpu_resp_valid;
  logic [WORD_SIZE-1:0]  cpu_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic                  mem_ack;
  logic [BLOCK_SIZE-1:0] mem_rdata;

  modport master (
    output cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_rdata, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_rdata, mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nway_wb_cache_ctrl.sv
// Purpose : N-way set-associative write-back, write-allocate cache with true-LRU replacement.
// Ports   : clk     - rising-edge clock
//           rst     - asynchronous active-high reset
//           bus     - nway_wb_cache_ctrl_if.slave (CPU valid/ready port + block memory req/ack port)
module nway_wb_cache_ctrl #(
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned NUM_BLOCKS      = 64,
  parameter int unsigned NUM_WAYS        = 4,
  parameter int unsigned ADDR_WIDTH      = 32
) (
  input logic               clk,
  input logic               rst,
  nway_wb_cache_ctrl_if.slave bus
);
  localparam int unsigned NUM_SETS   = NUM_BLOCKS / NUM_WAYS;
  localparam int unsigned OFFSET_W   = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned INDEX_W    = $clog2(NUM_SETS);
  localparam int unsigned TAG_W      = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int unsigned AGE_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned WAY_W      = AGE_W;
  localparam int unsigned BLOCK_SIZE = WORDS_PER_BLOCK * WORD_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t                r_state;
  logic                  r_req_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic [WAY_W-1:0]      r_victim;

  logic [TAG_W-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
  logic [BLOCK_SIZE-1:0] r_data  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]   r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0]   r_dirty [NUM_SETS];
  logic [AGE_W-1:0]      r_age   [NUM_SETS][NUM_WAYS];

  logic                  r_cpu_req_ready;
  logic                  r_cpu_resp_valid;
  logic [WORD_SIZE-1:0]  r_cpu_rdata;
  logic                  r_mem_req_valid;
  logic                  r_mem_req_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BLOCK_SIZE-1:0] r_mem_wdata;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [OFFSET_W-1:0]   w_off;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic [AGE_W-1:0]      w_hit_age;
  logic                  w_inv_found;
  logic [WAY_W-1:0]      w_victim;
  logic [BLOCK_SIZE-1:0] w_hit_line;
  logic [BLOCK_SIZE-1:0] w_merged;
  logic [WORD_SIZE-1:0]  w_hit_word;
  logic                  w_merge_en;
  logic                  w_fill_en;

  assign w_tag = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx = r_addr[OFFSET_W +: INDEX_W];
  assign w_off = r_addr[OFFSET_W-1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    w_inv_found = 1'b0;
    w_victim    = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (!w_inv_found && !r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_victim    = WAY_W'(w);
      end
    end
    if (!w_inv_found) begin
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        if (r_age[w_idx][w] == AGE_W'(NUM_WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
  end

  // Hit line word select and write merge.
  always_comb begin
    w_hit_line = r_data[w_idx][w_hit_way];
    w_hit_age  = r_age[w_idx][w_hit_way];
    w_hit_word = w_hit_line[int'(w_off)*int'(WORD_SIZE) +: WORD_SIZE];
    w_merged   = w_hit_line;
    w_merged[int'(w_off)*int'(WORD_SIZE) +: WORD_SIZE] = r_wdata;
  end

  assign w_merge_en = (r_state == S_COMPARE) && w_hit && r_req_we;
  assign w_fill_en  = (r_state == S_ALLOCATE) && r_mem_req_valid && bus.mem_ack;

  // Tag/data storage: not reset, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_fill_en) begin
      r_data[w_idx][r_victim] <= bus.mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end else if (w_merge_en) begin
      r_data[w_idx][w_hit_way] <= w_merged;
    end
  end

  // Controller FSM with registered outputs, valid/dirty and LRU ages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_req_we         <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_victim         <= '0;
      r_cpu_req_ready  <= 1'b1;
      r_cpu_resp_valid <= 1'b0;
      r_cpu_rdata      <= '0;
      r_mem_req_valid  <= 1'b0;
      r_mem_req_we     <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) r_age[s][w] <= AGE_W'(w);
      end
    end else begin
      r_cpu_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req_valid) begin
            r_req_we        <= bus.cpu_req_type;
            r_addr          <= bus.cpu_addr;
            r_wdata         <= bus.cpu_wdata;
            r_cpu_req_ready <= 1'b0;
            r_state         <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (r_req_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
            else          r_cpu_rdata <= w_hit_word;
            // Ways younger than the hit way age by one; the hit way becomes youngest.
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
              if (WAY_W'(w) == w_hit_way)           r_age[w_idx][w] <= '0;
              else if (r_age[w_idx][w] < w_hit_age) r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            end
            r_cpu_resp_valid <= 1'b1;
            r_cpu_req_ready  <= 1'b1;
            r_state          <= S_IDLE;
          end else begin
            r_victim        <= w_victim;
            r_mem_req_valid <= 1'b1;
            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
              r_mem_req_we <= 1'b1;
              r_mem_addr   <= {r_tag[w_idx][w_victim], w_idx, {OFFSET_W{1'b0}}};
              r_mem_wdata  <= r_data[w_idx][w_victim];
              r_state      <= S_WRITEBACK;
            end else begin
              r_mem_req_we <= 1'b0;
              r_mem_addr   <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
              r_state      <= S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ack) begin
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_mem_req_valid          <= 1'b0;
            r_state                  <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          // After a write-back the request drops for one cycle before the refill is issued.
          if (!r_mem_req_valid) begin
            r_mem_req_valid <= 1'b1;
            r_mem_req_we    <= 1'b0;
            r_mem_addr      <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
          end else if (bus.mem_ack) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_mem_req_valid          <= 1'b0;
            r_state                  <= S_COMPARE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_req_ready  = r_cpu_req_ready;
  assign bus.cpu_resp_valid = r_cpu_resp_valid;
  assign bus.cpu_rdata      = r_cpu_rdata;
  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_req_we     = r_mem_req_we;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
endmodule
